decoder_scan_seq: RTL and testbench
===================================

Name: decoder_scan_seq

Overview:
Sequential channel scanner that sits directly upstream of the 3-to-8 decoder. It drives the decoder's 3-bit select and enable. On start it steps the select through the unmasked channels of an 8-channel mask. Each channel is held for a programmable dwell time, in single-pass or continuous mode, and a one-cycle done pulse ends a single pass.

Parameters:
DWELL_W, 8, width of dwell count; each channel is held for dwell+1 cycles.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
start  input  1  request to begin a scan; sampled in IDLE only.
stop  input  1  abort an active scan.
mode  input  1  0 = single pass, 1 = continuous (wrap).
mask  input  8  channel enables; bit i set = channel i scanned.
dwell  input  DWELL_W  hold time per channel minus one.
sel  output  3  channel index to decoder select.
en  output  1  decoder enable.
busy  output  1  scan in progress.
done  output  1  one-cycle pulse at end of single pass or empty scan.

Behaviour:
- Reset and outputs:
  - Synchronous active-low reset: rst_n sampled low at a clk edge → state IDLE, sel=0, en=0, busy=0, done=0, dwell counter=0.
  - This applies mid-scan too; no done pulse is generated.
  - All outputs are registered.
- State machine: IDLE, ACTIVE. busy = en = (state==ACTIVE).
- IDLE transitions:
  - start=1, stop=0, mask!=0 → ACTIVE next cycle.
  - mask, dwell and mode are latched at this edge; later changes to them are ignored until the next start.
  - sel = lowest set bit of mask, cnt=0, en=1.
  - start=1 with mask==0 → stay IDLE; done=1 for exactly the next cycle; en stays 0.
  - start and stop both high → stop wins; stay IDLE, no done.
  - stop alone in IDLE is ignored.
  - In IDLE, sel holds its last value.
- ACTIVE: cnt increments every cycle; channel expiry when cnt==dwell_latched.
  - Expiry, next set mask bit exists above sel (search sel+1..7) → sel=that bit, cnt=0. Skipped channels cost no cycles.
  - Expiry on the last set bit, mode=1 → sel=lowest set bit, cnt=0. With a single-bit mask, sel stays constant and en stays high.
  - Expiry on the last set bit, mode=0 → IDLE next cycle, en=0, busy=0, done=1 for one cycle, sel holds the last channel.
  - stop=1 → IDLE next cycle, en=0, no done. stop takes priority over expiry.
  - start while ACTIVE is ignored.
- Timing rules:
  - Each scanned channel is presented with en=1 for exactly dwell+1 consecutive cycles.
  - en has no gap between channels.
  - dwell=0 → sel changes every cycle.
  - Latency: start sampled at edge N → en=1 and first sel valid after edge N.
  - Single pass over k channels: en high for k*(dwell+1) cycles; done high in the cycle immediately after en falls.
- Counter: DWELL_W bits, never exceeds dwell_latched, no overflow.
- Downstream contract: the decoder sees en=0 whenever the scanner is idle, so all decoder outputs are 0 outside a scan.

Test Plan:
- Reset mid-scan: run mask=8'hFF, dwell=3, mode=1; drive rst_n=0 for 2 cycles at cycle 6 → sel=0, en=0, busy=0, done=0 after the first reset edge; no done pulse.
- Single pass: mask=8'hFF, dwell=1, mode=0, start pulse → sel 0,0,1,1,...,7,7 with en=1 for 16 cycles; en=0 and done=1 in cycle 17; done=0 in cycle 18.
- Sparse continuous: mask=8'b1010_0100, dwell=0, mode=1 → sel 2,5,7,2,5,7,... every cycle; en never drops; busy=1 throughout.
- Stop priority: continuous scan with mask=8'h81, dwell=2; assert stop in the same cycle as an expiry → en=0 next cycle, done stays 0, sel holds 0 or 7 (no advance).
- Empty mask: mask=0, start → done=1 for one cycle, en and busy never assert; start and stop together in IDLE → no done, no scan.
- Snapshot and ignore: start with mask=8'h0F, dwell=1; at cycle 3 change mask to 8'hF0, dwell to 5, and pulse start → scan still covers channels 0-3, 2 cycles each, then done.

Source files
------------

// File: rtl/decoder_scan_seq_if.sv
// Scanner-to-host bus: scan controls in, decoder select/enable and status out.
// The master drives the controls; the scanner is the slave.
interface decoder_scan_seq_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         sel;
    logic               en;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, mode, mask, dwell,
        input  sel, en, busy, done
    );

    modport slave (
        input  start, stop, mode, mask, dwell,
        output sel, en, busy, done
    );
endinterface

// File: rtl/decoder_scan_seq.sv
// Channel scanner feeding a 3-to-8 decoder: walks sel over the set bits of a
// latched mask, holding each channel dwell+1 cycles, single-pass or wrapping.
module decoder_scan_seq #(
    parameter int DWELL_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    decoder_scan_seq_if.slave bus
);
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               mode_q, mode_d;

    // Index of the lowest set bit; only meaningful for a non-zero mask.
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = i[2:0];
        end
        return r;
    endfunction

    // Nearest set bit strictly above the current channel, if any.
    logic       next_found;
    logic [2:0] next_sel;

    always_comb begin
        next_found = 1'b0;
        next_sel   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (4'(i) > {1'b0, sel_q})) begin
                next_found = 1'b1;
                next_sel   = i[2:0];
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;

        unique case (state_q)
            IDLE: begin
                // stop beats start; stop alone is a no-op here.
                if (bus.start && !bus.stop) begin
                    if (bus.mask != 8'd0) begin
                        state_d = ACTIVE;
                        mask_d  = bus.mask;
                        dwell_d = bus.dwell;
                        mode_d  = bus.mode;
                        sel_d   = lowest_bit(bus.mask);
                        cnt_d   = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == dwell_q) begin
                    cnt_d = '0;
                    if (next_found) begin
                        sel_d = next_sel;
                    end else if (mode_q) begin
                        sel_d = lowest_bit(mask_q);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            mask_q  <= 8'd0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
        end
    end

    // With a one-bit state encoding, en/busy come straight off the state flop.
    assign bus.sel  = sel_q;
    assign bus.en   = (state_q == ACTIVE);
    assign bus.busy = (state_q == ACTIVE);
    assign bus.done = done_q;
endmodule

// File: tb/tb_decoder_scan_seq.sv
// Self-checking bench for decoder_scan_seq: directed scenarios plus random
// scans compared against a channel-list model built from the mask and dwell.
module tb_decoder_scan_seq;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_q[$];
    logic [2:0] model_sel = 3'd0;

    always #5 clk = ~clk;

    decoder_scan_seq_if #(.DWELL_W(DW)) bus ();

    decoder_scan_seq #(.DWELL_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Expected sel per cycle of one pass: each set channel, ascending, dwell+1 times.
    function automatic void build_seq(input logic [7:0] m, input int d);
        exp_q.delete();
        for (int c = 0; c < 8; c++) begin
            if (m[c]) begin
                for (int r = 0; r <= d; r++) exp_q.push_back(c);
            end
        end
    endfunction

    // Inputs change at negedge and are sampled by the next posedge.
    task automatic start_scan(input logic [7:0] m, input logic [DW-1:0] d, input logic md);
        bus.mask  = m;
        bus.dwell = d;
        bus.mode  = md;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Checks scan cycles k0..k1-1 against exp_q (wrapping for continuous mode).
    task automatic check_seq(input string name, input int k0, input int k1, input bit scramble);
        logic [5:0] got, exp;
        for (int k = k0; k < k1; k++) begin
            got = {bus.en, bus.busy, bus.done, bus.sel};
            exp = {3'b110, 3'(exp_q[k % exp_q.size()])};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: {en,busy,done,sel} got %b expected %b", name, k, got, exp);
            end
            if (scramble) begin
                bus.mask  = 8'($urandom);
                bus.dwell = DW'($urandom);
                bus.mode  = 1'($urandom);
                bus.start = 1'($urandom);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
        bus.mask = 8'd0; bus.dwell = '0;
        @(negedge clk);
        got = {bus.en, bus.busy, bus.done, bus.sel};
        n_checks++;
        if (got !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_init: got %b expected 000000", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Mid-scan reset: continuous FF scan, reset asserted at cycle 6 for 2 cycles.
        build_seq(8'hFF, 3);
        start_scan(8'hFF, 8'd3, 1'b1);
        check_seq("reset_pre", 0, 5, 0);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = {bus.en, bus.busy, bus.done, bus.sel};
            n_checks++;
            if (got !== 6'b000000) begin
                n_fail++;
                $display("FAIL reset_mid edge %0d: got %b expected 000000", i, got);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {bus.en, bus.busy, bus.done, bus.sel};
            n_checks++;
            if (got !== 6'b000000) begin
                n_fail++;
                $display("FAIL reset_after %0d: got %b expected 000000", i, got);
            end
        end
        model_sel = 3'd0;
    endtask

    // Single pass with done check; scramble exercises the input snapshot.
    task automatic run_single(input string name, input logic [7:0] m, input int d, input bit scramble);
        logic [5:0] got;
        logic [2:0] last;
        build_seq(m, d);
        last = 3'(exp_q[exp_q.size() - 1]);
        start_scan(m, DW'(d), 1'b0);
        check_seq(name, 0, exp_q.size(), scramble);
        got = {bus.en, bus.busy, bus.done, bus.sel};
        n_checks++;
        if (got !== {3'b001, last}) begin
            n_fail++;
            $display("FAIL %s done_pulse: got %b expected %b", name, got, {3'b001, last});
        end
        @(negedge clk);
        got = {bus.en, bus.busy, bus.done, bus.sel};
        n_checks++;
        if (got !== {3'b000, last}) begin
            n_fail++;
            $display("FAIL %s done_clear: got %b expected %b", name, got, {3'b000, last});
        end
        model_sel = last;
    endtask

    task automatic test_single_pass();
        run_single("single_pass", 8'hFF, 1, 0);
        run_single("max_dwell", 8'h80, 255, 0);
    endtask

    // Continuous scan for ncyc cycles, then stop; sel must freeze on the stopped channel.
    task automatic run_cont(input string name, input logic [7:0] m, input int d, input int ncyc, input bit scramble);
        logic [5:0] got;
        logic [2:0] hold;
        build_seq(m, d);
        start_scan(m, DW'(d), 1'b1);
        check_seq(name, 0, ncyc, scramble);
        hold = 3'(exp_q[ncyc % exp_q.size()]);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        got = {bus.en, bus.busy, bus.done, bus.sel};
        n_checks++;
        if (got !== {3'b000, hold}) begin
            n_fail++;
            $display("FAIL %s stop: got %b expected %b", name, got, {3'b000, hold});
        end
        @(negedge clk);
        got = {bus.en, bus.busy, bus.done, bus.sel};
        n_checks++;
        if (got !== {3'b000, hold}) begin
            n_fail++;
            $display("FAIL %s stop_idle: got %b expected %b", name, got, {3'b000, hold});
        end
        model_sel = hold;
    endtask

    task automatic test_sparse_continuous();
        run_cont("sparse_cont", 8'b1010_0100, 0, 12, 0);
    endtask

    // Stop lands on the expiry edge of channel 0 (k=2) and of channel 7 (k=5).
    task automatic test_stop_priority();
        run_cont("stop_prio_ch0", 8'h81, 2, 2, 0);
        run_cont("stop_prio_ch7", 8'h81, 2, 5, 0);
    endtask

    task automatic test_empty_mask();
        logic [5:0] got;
        start_scan(8'h00, 8'd2, 1'b0);
        got = {bus.en, bus.busy, bus.done, bus.sel};
        n_checks++;
        if (got !== {3'b001, model_sel}) begin
            n_fail++;
            $display("FAIL empty_done: got %b expected %b", got, {3'b001, model_sel});
        end
        @(negedge clk);
        got = {bus.en, bus.busy, bus.done, bus.sel};
        n_checks++;
        if (got !== {3'b000, model_sel}) begin
            n_fail++;
            $display("FAIL empty_clear: got %b expected %b", got, {3'b000, model_sel});
        end
        bus.mask = 8'hFF; bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got = {bus.en, bus.busy, bus.done, bus.sel};
            n_checks++;
            if (got !== {3'b000, model_sel}) begin
                n_fail++;
                $display("FAIL start_stop_idle %0d: got %b expected %b", i, got, {3'b000, model_sel});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_snapshot();
        logic [5:0] got;
        build_seq(8'h0F, 1);
        start_scan(8'h0F, 8'd1, 1'b0);
        check_seq("snapshot", 0, 2, 0);
        bus.mask = 8'hF0; bus.dwell = 8'd5; bus.start = 1'b1;
        check_seq("snapshot", 2, 3, 0);
        check_seq("snapshot", 3, 8, 0);
        got = {bus.en, bus.busy, bus.done, bus.sel};
        n_checks++;
        if (got !== 6'b001011) begin
            n_fail++;
            $display("FAIL snapshot_done: got %b expected 001011", got);
        end
        @(negedge clk);
        model_sel = 3'd3;
    endtask

    task automatic test_random();
        logic [7:0] m;
        int d;
        for (int it = 0; it < 20; it++) begin
            m = 8'($urandom);
            if (m == 8'd0) m = 8'd1 << $urandom_range(0, 7);
            d = $urandom_range(0, 3);
            build_seq(m, d);
            if ($urandom_range(0, 1) == 0)
                run_single("rand_single", m, d, 1);
            else
                run_cont("rand_cont", m, d, 2 * exp_q.size() + $urandom_range(0, 4), 1);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_sparse_continuous();
        test_stop_priority();
        test_empty_mask();
        test_snapshot();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
